// File: rtl/pixel_config.sv
// Shared pixel configuration: default field widths and the
// pulse sequencer state encoding.
package pixel_config;

   localparam int CNT_W_DEF = 16;
   localparam int WID_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      FIN  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/pulse_width_cnt.sv
// High-phase width counter: counts cycles spent in HIGH and flags
// the final cycle of the pulse.
module pulse_width_cnt #(
   parameter int WID_W = 8
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [WID_W-1:0] w_eff,
   output logic             last
);

   logic [WID_W-1:0] cnt_q;
   logic [WID_W-1:0] cnt_d;

   // clear outside HIGH, saturating count while high
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !(&cnt_q)) begin
         cnt_d = cnt_q + WID_W'(1);
      end
   end

   // count register
   always_ff @(posedge clk_in) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last = (cnt_q == (w_eff - WID_W'(1)));

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Pulse train sequencer: emits pulse_num stretched pulses of a
// given width and period on a registered pulse_out.
module pulse_seq_ctrl
   import pixel_config::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int WID_W = WID_W_DEF
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] pulse_num,
   input  logic [CNT_W-1:0] pulse_period,
   input  logic [WID_W-1:0] pulse_width,
   output logic             pulse_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pulse_cnt
);

   localparam int EXT_W = ((CNT_W > WID_W) ? CNT_W : WID_W) + 1;

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic [CNT_W-1:0] per_q, per_d;
   logic [WID_W-1:0] wid_q, wid_d;
   logic [CNT_W-1:0] pcnt_q, pcnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse_q, pulse_d;

   logic [WID_W-1:0] w_eff;
   logic [EXT_W-1:0] w_plus1;
   logic [EXT_W-1:0] per_x;
   logic [EXT_W-1:0] p_eff;
   logic [CNT_W-1:0] pcnt_inc;
   logic             per_elapsed;
   logic             w_last;
   logic             go;

   assign w_eff    = (wid_q == '0) ? WID_W'(1) : wid_q;
   assign w_plus1  = EXT_W'(w_eff) + EXT_W'(1);
   assign per_x    = EXT_W'(per_q);
   assign p_eff    = (per_x > w_plus1) ? per_x : w_plus1;
   assign pcnt_inc = (&pcnt_q) ? pcnt_q : pcnt_q + CNT_W'(1);
   assign per_elapsed = (EXT_W'(pcnt_q) >= p_eff) || (&pcnt_q);
   assign go       = start && !abort;

   pulse_width_cnt #(
      .WID_W (WID_W)
   ) u_wcnt (
      .clk_in (clk_in),
      .rst    (rst),
      .clr    (state_q != HIGH),
      .en     (state_q == HIGH),
      .w_eff  (w_eff),
      .last   (w_last)
   );

   // next-state, config latch and counter updates
   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      per_d   = per_q;
      wid_d   = wid_q;
      pcnt_d  = pcnt_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE, FIN: begin
            state_d = IDLE;
            if (go) begin
               num_d = pulse_num;
               per_d = pulse_period;
               wid_d = pulse_width;
               cnt_d = '0;
               if (pulse_num == '0) begin
                  state_d = FIN;
               end else begin
                  state_d = HIGH;
                  cnt_d   = CNT_W'(1);
                  pcnt_d  = CNT_W'(1);
               end
            end
         end
         HIGH: begin
            pcnt_d = pcnt_inc;
            if (abort) begin
               state_d = FIN;
            end else if (w_last) begin
               state_d = (cnt_q == num_q) ? FIN : LOW;
            end
         end
         LOW: begin
            pcnt_d = pcnt_inc;
            if (abort) begin
               state_d = FIN;
            end else if (per_elapsed) begin
               state_d = HIGH;
               cnt_d   = cnt_q + CNT_W'(1);
               pcnt_d  = CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      pulse_d = (state_d == HIGH);
   end

   // state and datapath registers
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q <= IDLE;
         num_q   <= '0;
         per_q   <= '0;
         wid_q   <= '0;
         pcnt_q  <= '0;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         per_q   <= per_d;
         wid_q   <= wid_d;
         pcnt_q  <= pcnt_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse_out = pulse_q;
   assign busy      = (state_q == HIGH) || (state_q == LOW);
   assign done      = (state_q == FIN);
   assign pulse_cnt = cnt_q;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Scoreboard bench for pulse_seq_ctrl: hand-derived pulse edges
// and done strobes are queued and matched by a monitor.
module tb_pulse_seq_ctrl;

   localparam int K_RISE = 0;
   localparam int K_FALL = 1;
   localparam int K_DONE = 2;

   typedef struct {
      int kind;
      int cyc;
      int val;
   } ev_t;

   logic        clk_in = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] pulse_num = '0;
   logic [15:0] pulse_period = '0;
   logic [7:0]  pulse_width = '0;
   logic        pulse_out;
   logic        busy;
   logic        done;
   logic [15:0] pulse_cnt;

   ev_t exp_q[$];
   int  cyc = 0;
   int  base = 0;
   int  total = 0;
   int  bad = 0;
   int  hi_len = 0;
   logic prev_po = 1'b0;

   pulse_seq_ctrl dut (
      .clk_in       (clk_in),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .pulse_num    (pulse_num),
      .pulse_period (pulse_period),
      .pulse_width  (pulse_width),
      .pulse_out    (pulse_out),
      .busy         (busy),
      .done         (done),
      .pulse_cnt    (pulse_cnt)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(string nm, int act, int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cyc %0d)",
                  nm, act, exp, cyc - base);
      end
   endtask

   task automatic push(int k, int c, int v);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic pop_chk(int k, int c, int v);
      ev_t e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_event: got kind %0d cyc %0d val %0d, want none",
                  k, c, v);
      end else begin
         e = exp_q.pop_front();
         chk("ev_kind", k, e.kind);
         chk("ev_cyc", c, e.cyc);
         chk("ev_val", v, e.val);
      end
   endtask

   // monitor: turn DUT output activity into events
   always @(negedge clk_in) begin
      int rel;
      rel = cyc - base;
      if (pulse_out && !prev_po) pop_chk(K_RISE, rel, 0);
      if (!pulse_out && prev_po) pop_chk(K_FALL, rel, hi_len);
      if (done) pop_chk(K_DONE, rel, int'(pulse_cnt));
      if (pulse_out) hi_len = prev_po ? hi_len + 1 : 1;
      prev_po = pulse_out;
   end

   task automatic tick(int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic issue(int n, int p, int w);
      base = cyc;
      pulse_num = 16'(n);
      pulse_period = 16'(p);
      pulse_width = 8'(w);
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int quiet;

      // reset state
      tick(3);
      chk("rst_pulse_out", int'(pulse_out), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_pulse_cnt", int'(pulse_cnt), 0);
      rst = 1'b0;
      tick(2);

      // num=3 period=10 width=3
      for (int k = 0; k < 3; k++) begin
         push(K_RISE, 1 + 10 * k, 0);
         push(K_FALL, 4 + 10 * k, 3);
      end
      push(K_DONE, 24, 3);
      issue(3, 10, 3);
      chk("t1_busy", int'(busy), 1);
      pulse_period = 16'd2;
      pulse_width = 8'd1;
      pulse_num = 16'd9;
      tick(30);
      chk("t1_cnt", int'(pulse_cnt), 3);
      chk("t1_idle", int'(busy), 0);
      chk("t1_drained", exp_q.size(), 0);

      // num=0: immediate done, no pulse, never busy
      push(K_DONE, 1, 0);
      issue(0, 10, 3);
      quiet = int'(busy | pulse_out);
      for (int i = 0; i < 4; i++) begin
         tick(1);
         quiet = quiet | int'(busy | pulse_out);
      end
      chk("t2_quiet", quiet, 0);
      chk("t2_drained", exp_q.size(), 0);

      // width=0 period=2: alternating 1,0
      for (int k = 0; k < 4; k++) begin
         push(K_RISE, 1 + 2 * k, 0);
         push(K_FALL, 2 + 2 * k, 1);
      end
      push(K_DONE, 8, 4);
      issue(4, 2, 0);
      pulse_width = 8'd9;
      pulse_period = 16'd50;
      tick(12);
      chk("t3_drained", exp_q.size(), 0);

      // width=8 period=4: period stretched to 9
      push(K_RISE, 1, 0);
      push(K_FALL, 9, 8);
      push(K_RISE, 10, 0);
      push(K_FALL, 18, 8);
      push(K_DONE, 18, 2);
      issue(2, 4, 8);
      tick(22);
      chk("t4_drained", exp_q.size(), 0);

      // abort during pulse 2, ignored start while busy
      push(K_RISE, 1, 0);
      push(K_FALL, 4, 3);
      push(K_RISE, 11, 0);
      push(K_FALL, 13, 2);
      push(K_DONE, 13, 2);
      issue(5, 10, 3);
      tick(4);
      pulse_num = 16'd1;
      pulse_period = 16'd4;
      pulse_width = 8'd7;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("t5_busy", int'(busy), 1);
      tick(6);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk("t5_out_low", int'(pulse_out), 0);
      chk("t5_done", int'(done), 1);
      chk("t5_cnt", int'(pulse_cnt), 2);
      tick(10);
      chk("t5_cnt_hold", int'(pulse_cnt), 2);
      chk("t5_drained", exp_q.size(), 0);

      // start with abort: abort wins
      base = cyc;
      pulse_num = 16'd3;
      start = 1'b1;
      abort = 1'b1;
      tick(1);
      start = 1'b0;
      abort = 1'b0;
      chk("t6_busy", int'(busy), 0);
      tick(3);
      chk("t6_busy_late", int'(busy), 0);
      chk("t6_out", int'(pulse_out), 0);

      // reset mid-train at cycle 1000
      while (cyc < 938) tick(1);
      for (int k = 0; k < 7; k++) begin
         push(K_RISE, 1 + 10 * k, 0);
         if (k < 6) push(K_FALL, 4 + 10 * k, 3);
      end
      push(K_FALL, 63, 2);
      issue(200, 10, 3);
      while (cyc < 1000) tick(1);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("t7_rst_outs",
             int'({pulse_out, busy, done, |pulse_cnt}), 0);
      end
      rst = 1'b0;
      tick(2);
      push(K_RISE, 1, 0);
      push(K_FALL, 3, 2);
      push(K_RISE, 6, 0);
      push(K_FALL, 8, 2);
      push(K_DONE, 8, 2);
      issue(2, 5, 2);
      tick(12);
      chk("t7_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
